// File: rtl/riscv_pkg.sv
// Shared core types: memory geometry, arbiter state and response tags.
// Imported by the memory arbiter and its response tag pipe.
package riscv_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int NB_COL     = 4;
  localparam int COL_WIDTH  = 8;
  localparam int MAX_RD_LAT = 3;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_DRAIN,
    ARB_HALTED
  } arb_state_t;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } rsp_tag_t;

endpackage

// File: rtl/briski_rsp_tag_pipe.sv
// Read-response tag shift register matching the BRAM read latency.
// Flags core reads that are still pending beyond the current cycle.
module briski_rsp_tag_pipe
  import riscv_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     clr_i,
  input  rsp_tag_t tag_i,
  output rsp_tag_t tag_o,
  output logic     has_core_o
);

  rsp_tag_t stg_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign tag_o = stg_q[RD_LAT-1];

  // The exiting stage is answered this cycle, so it no longer blocks halt.
  always_comb begin
    has_core_o = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      has_core_o = has_core_o |
        (stg_q[i].valid && stg_q[i].owner == OWNER_CORE);
    end
  end

endmodule

// File: rtl/briski_mem_arbiter.sv
// Round-robin arbiter for the shared BRAM port between core and host,
// with read-response routing and a halt/drain FSM for host exclusive access.
module briski_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter int NB_COL     = riscv_pkg::NB_COL,
  parameter int COL_WIDTH  = riscv_pkg::COL_WIDTH,
  parameter int RD_LAT     = 1,
  localparam int DW        = NB_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic                  core_req_we,
  input  logic [NB_COL-1:0]     core_req_be,
  input  logic [ADDR_WIDTH-1:0] core_req_addr,
  input  logic [DW-1:0]         core_req_wdata,
  output logic                  core_rsp_valid,
  output logic [DW-1:0]         core_rsp_rdata,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_req_we,
  input  logic [NB_COL-1:0]     host_req_be,
  input  logic [ADDR_WIDTH-1:0] host_req_addr,
  input  logic [DW-1:0]         host_req_wdata,
  output logic                  host_rsp_valid,
  output logic [DW-1:0]         host_rsp_rdata,
  input  logic                  host_halt_req,
  output logic                  core_halted,
  output logic                  mem_en,
  output logic [NB_COL-1:0]     mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("briski_mem_arbiter: RD_LAT must be 1..3");
  end

  arb_state_t state_q;
  mem_owner_t last_q;
  logic       core_ok;
  logic       host_ok;
  logic       gnt_c;
  logic       gnt_h;
  logic       has_core;
  rsp_tag_t   tag_in;
  rsp_tag_t   tag_out;

  always_comb begin
    core_ok = reset_n && core_req_valid && state_q == ARB_RUN;
    host_ok = reset_n && host_req_valid;
    gnt_c   = core_ok && (!host_ok || last_q == OWNER_HOST);
    gnt_h   = host_ok && !gnt_c;
  end

  assign core_req_ready = gnt_c;
  assign host_req_ready = gnt_h;

  always_comb begin
    mem_en    = gnt_c | gnt_h;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt_c: begin
        mem_we    = core_req_we ? core_req_be : '0;
        mem_addr  = core_req_addr;
        mem_wdata = core_req_wdata;
      end
      gnt_h: begin
        mem_we    = host_req_we ? host_req_be : '0;
        mem_addr  = host_req_addr;
        mem_wdata = host_req_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    tag_in.valid = (gnt_c && !core_req_we) || (gnt_h && !host_req_we);
    tag_in.owner = gnt_h ? OWNER_HOST : OWNER_CORE;
  end

  briski_rsp_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tags (
    .clk        (clk),
    .clr_i      (!reset_n),
    .tag_i      (tag_in),
    .tag_o      (tag_out),
    .has_core_o (has_core)
  );

  always_comb begin
    core_rsp_valid = reset_n && tag_out.valid &&
                     tag_out.owner == OWNER_CORE;
    host_rsp_valid = reset_n && tag_out.valid &&
                     tag_out.owner == OWNER_HOST;
    core_rsp_rdata = core_rsp_valid ? mem_rdata : '0;
    host_rsp_rdata = host_rsp_valid ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ARB_RUN;
      last_q      <= OWNER_HOST;
      core_halted <= 1'b0;
    end else begin
      if (mem_en) begin
        last_q <= gnt_h ? OWNER_HOST : OWNER_CORE;
      end
      unique case (state_q)
        ARB_RUN: begin
          if (host_halt_req) state_q <= ARB_DRAIN;
        end
        ARB_DRAIN: begin
          // Dropping the halt request wins over completing the drain.
          if (!host_halt_req) begin
            state_q <= ARB_RUN;
          end else if (!has_core) begin
            state_q     <= ARB_HALTED;
            core_halted <= 1'b1;
          end
        end
        ARB_HALTED: begin
          if (!host_halt_req) begin
            state_q     <= ARB_RUN;
            core_halted <= 1'b0;
          end
        end
        default: begin
          state_q     <= ARB_RUN;
          core_halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_briski_mem_arbiter.sv
// Bench for briski_mem_arbiter: three DUTs (RD_LAT 1..3) share one stimulus
// table; a shadow memory and read queue predict every response.
module tb_briski_mem_arbiter;
  import riscv_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic          rst;
    logic          cv;
    logic          cwe;
    logic [3:0]    cbe;
    logic [AW-1:0] ca;
    logic [31:0]   cd;
    logic          hv;
    logic          hwe;
    logic [3:0]    hbe;
    logic [AW-1:0] ha;
    logic [31:0]   hd;
    logic          halt;
    logic          ec;
    logic          eh;
    logic [2:0]    ehalt;
  } vec_t;

  typedef struct {
    int          c;
    logic        own;
    logic [31:0] d;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n;
  logic cv, cwe, hv, hwe, halt;
  logic [3:0] cbe, hbe;
  logic [AW-1:0] ca, ha;
  logic [31:0] cd, hd;

  logic [2:0] crdy, hrdy, crv, hrv, men, chalt;
  logic [31:0] crd [3];
  logic [31:0] hrd [3];
  logic [31:0] mwd [3];
  logic [31:0] mrd [3];
  logic [3:0] mwe [3];
  logic [AW-1:0] mad [3];

  logic [31:0] shadow [DEPTH];
  sb_t sb [$];
  vec_t tv [$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g + 1;
    logic [31:0] ram [DEPTH];
    logic [31:0] rp [L];

    initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    end

    always @(posedge clk) begin
      if (men[g]) begin
        rp[0] <= ram[mad[g]];
        for (int b = 0; b < 4; b++) begin
          if (mwe[g][b]) ram[mad[g]][b*8 +: 8] <= mwd[g][b*8 +: 8];
        end
      end
      for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
    end

    assign mrd[g] = rp[L-1];

    briski_mem_arbiter #(
      .RD_LAT (L)
    ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .core_req_valid (cv),
      .core_req_ready (crdy[g]),
      .core_req_we    (cwe),
      .core_req_be    (cbe),
      .core_req_addr  (ca),
      .core_req_wdata (cd),
      .core_rsp_valid (crv[g]),
      .core_rsp_rdata (crd[g]),
      .host_req_valid (hv),
      .host_req_ready (hrdy[g]),
      .host_req_we    (hwe),
      .host_req_be    (hbe),
      .host_req_addr  (ha),
      .host_req_wdata (hd),
      .host_rsp_valid (hrv[g]),
      .host_rsp_rdata (hrd[g]),
      .host_halt_req  (halt),
      .core_halted    (chalt[g]),
      .mem_en         (men[g]),
      .mem_we         (mwe[g]),
      .mem_addr       (mad[g]),
      .mem_wdata      (mwd[g]),
      .mem_rdata      (mrd[g])
    );
  end

  function automatic vec_t mk(
    logic rst, logic c_v, logic c_we, logic [3:0] c_be,
    logic [AW-1:0] c_a, logic [31:0] c_d,
    logic h_v, logic h_we, logic [3:0] h_be,
    logic [AW-1:0] h_a, logic [31:0] h_d,
    logic hlt, logic e_c, logic e_h, logic [2:0] e_halt);
    vec_t v;
    v.rst = rst; v.cv = c_v; v.cwe = c_we; v.cbe = c_be;
    v.ca = c_a; v.cd = c_d; v.hv = h_v; v.hwe = h_we;
    v.hbe = h_be; v.ha = h_a; v.hd = h_d; v.halt = hlt;
    v.ec = e_c; v.eh = e_h; v.ehalt = e_halt;
    return v;
  endfunction

  function automatic vec_t idle(logic hlt, logic [2:0] e_halt);
    return mk(0, 0,0,0,0,0, 0,0,0,0,0, hlt, 0,0, e_halt);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic issue(logic we, logic [3:0] be, logic [AW-1:0] a,
                       logic [31:0] d, logic own);
    if (!we) begin
      sb.push_back('{cyc, own, shadow[a]});
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic apply(vec_t v, int idx);
    logic [3:0] ew;
    logic [AW-1:0] ea;
    logic [31:0] ewd, ed;
    logic ecv, ehv;
    @(posedge clk);
    #1;
    cyc++;
    reset_n = !v.rst;
    cv = v.cv; cwe = v.cwe; cbe = v.cbe; ca = v.ca; cd = v.cd;
    hv = v.hv; hwe = v.hwe; hbe = v.hbe; ha = v.ha; hd = v.hd;
    halt = v.halt;
    @(negedge clk);
    if (v.rst) sb.delete();
    ew = '0; ea = '0; ewd = '0;
    if (v.ec) begin
      ew = v.cwe ? v.cbe : 4'h0; ea = v.ca; ewd = v.cd;
    end else if (v.eh) begin
      ew = v.hwe ? v.hbe : 4'h0; ea = v.ha; ewd = v.hd;
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("v%0d L%0d core_ready", idx, g+1), crdy[g], v.ec);
      chk($sformatf("v%0d L%0d host_ready", idx, g+1), hrdy[g], v.eh);
      chk($sformatf("v%0d L%0d mem_en", idx, g+1), men[g], v.ec | v.eh);
      chk($sformatf("v%0d L%0d mem_we", idx, g+1), mwe[g], ew);
      chk($sformatf("v%0d L%0d mem_addr", idx, g+1), mad[g], ea);
      chk($sformatf("v%0d L%0d mem_wdata", idx, g+1), mwd[g], ewd);
      chk($sformatf("v%0d L%0d core_halted", idx, g+1), chalt[g],
          v.ehalt[g]);
      ecv = 1'b0; ehv = 1'b0; ed = '0;
      foreach (sb[i]) begin
        if (sb[i].c + g + 1 == cyc) begin
          if (sb[i].own) ehv = 1'b1;
          else ecv = 1'b1;
          ed = sb[i].d;
        end
      end
      chk($sformatf("v%0d L%0d core_rsp_valid", idx, g+1), crv[g], ecv);
      chk($sformatf("v%0d L%0d core_rsp_rdata", idx, g+1), crd[g],
          ecv ? ed : 32'h0);
      chk($sformatf("v%0d L%0d host_rsp_valid", idx, g+1), hrv[g], ehv);
      chk($sformatf("v%0d L%0d host_rsp_rdata", idx, g+1), hrd[g],
          ehv ? ed : 32'h0);
    end
    while (sb.size() > 0 && sb[0].c + MAX_RD_LAT < cyc) void'(sb.pop_front());
    if (v.ec) issue(v.cwe, v.cbe, v.ca, v.cd, 1'b0);
    if (v.eh) issue(v.hwe, v.hbe, v.ha, v.hd, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    cv = 0; cwe = 0; cbe = 0; ca = 0; cd = 0;
    hv = 0; hwe = 0; hbe = 0; ha = 0; hd = 0; halt = 0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

    // reset with both requesters asserting
    tv.push_back(mk(1, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 0,0,0));
    tv.push_back(mk(1, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 0,0,0));
    tv.push_back(idle(0, 0));
    // host preload
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,'hF,'h010,'hDEADBEEF, 0, 0,1,0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,'hF,'h011,'hCAFEF00D, 0, 0,1,0));
    // conflicts alternate C,H,C,H
    tv.push_back(mk(0, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 1,0,0));
    tv.push_back(mk(0, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 0,1,0));
    tv.push_back(mk(0, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 1,0,0));
    tv.push_back(mk(0, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 0,1,0));
    // core-only read, partial write, read back
    tv.push_back(mk(0, 1,0,0,'h010,0, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(mk(0, 1,1,'h3,'h012,'h12345678, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(mk(0, 1,0,0,'h012,0, 0,0,0,0,0, 0, 1,0,0));
    // host write with no byte enables
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,'h0,'h010,'hFFFFFFFF, 0, 0,1,0));
    tv.push_back(mk(0, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 1,0,0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,0,0,'h011,0, 0, 0,1,0));
    tv.push_back(mk(0, 1,1,'hF,'h013,'hAABBCCDD,
                    1,1,'hC,'h014,'h11223344, 0, 1,0,0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,'hC,'h014,'h11223344, 0, 0,1,0));
    tv.push_back(mk(0, 1,0,0,'h014,0, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,0,0,'h013,0, 0, 0,1,0));
    for (int i = 0; i < 4; i++) tv.push_back(idle(0, 0));
    // halt with a core read in flight
    tv.push_back(mk(0, 1,0,0,'h010,0, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(idle(1, 0));
    tv.push_back(mk(0, 1,0,0,'h011,0, 1,1,'hF,'h020,'hA0, 1, 0,1,3'b000));
    tv.push_back(mk(0, 1,0,0,'h011,0, 1,1,'hF,'h021,'hA1, 1, 0,1,3'b011));
    tv.push_back(mk(0, 1,0,0,'h011,0, 1,1,'hF,'h022,'hA2, 1, 0,1,3'b111));
    tv.push_back(mk(0, 1,0,0,'h011,0, 1,1,'hF,'h023,'hA3, 1, 0,1,3'b111));
    tv.push_back(mk(0, 1,0,0,'h011,0, 0,0,0,0,0, 0, 0,0,3'b111));
    tv.push_back(mk(0, 1,0,0,'h011,0, 0,0,0,0,0, 0, 1,0,3'b000));
    for (int i = 0; i < 3; i++) tv.push_back(idle(0, 0));
    // halt dropped during drain
    tv.push_back(mk(0, 1,0,0,'h012,0, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(idle(1, 0));
    tv.push_back(mk(0, 1,0,0,'h013,0, 0,0,0,0,0, 0, 0,0,0));
    tv.push_back(mk(0, 1,0,0,'h013,0, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(idle(0, 0));
    for (int i = 0; i < 3; i++) tv.push_back(idle(0, 0));
    // reset with two core reads in flight
    tv.push_back(mk(0, 1,0,0,'h010,0, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(mk(0, 1,0,0,'h011,0, 0,0,0,0,0, 0, 1,0,0));
    tv.push_back(mk(1, 1,0,0,'h012,0, 1,0,0,'h013,0, 0, 0,0,0));
    tv.push_back(idle(0, 0));
    tv.push_back(mk(0, 1,0,0,'h010,0, 1,0,0,'h011,0, 0, 1,0,0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,0,0,'h011,0, 0, 0,1,0));
    for (int i = 0; i < 4; i++) tv.push_back(idle(0, 0));

    foreach (tv[i]) apply(tv[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/briski_mem_arbiter.md
Name: briski_mem_arbiter

Overview:
Shares the single read/write port of the unified instruction+data BRAM between two requesters: the core load/store unit (core) and the external program loader/debug host (host). Performs per-cycle round-robin arbitration and tracks in-flight reads so each read response returns to its issuer. Provides a halt/drain state machine that gives the host exclusive memory access while the core is stalled. Sits between the memory stage and the byte-column BRAM.

Parameters:
ADDR_WIDTH, riscv_pkg::ADDR_WIDTH, word address width of the BRAM
NB_COL, riscv_pkg::NB_COL (4), byte columns per word
COL_WIDTH, riscv_pkg::COL_WIDTH (8), bits per column; data width DW = NB_COL*COL_WIDTH
RD_LAT, 1, BRAM read latency in cycles; legal range 1..3, elaboration error otherwise

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
core_req_valid  in  1  core request present
core_req_ready  out  1  core request accepted this cycle
core_req_we  in  1  1 = write, 0 = read
core_req_be  in  NB_COL  byte enables (writes only)
core_req_addr  in  ADDR_WIDTH  word address
core_req_wdata  in  DW  write data
core_rsp_valid  out  1  read data valid for core
core_rsp_rdata  out  DW  read data
host_req_valid, host_req_ready, host_req_we, host_req_be, host_req_addr, host_req_wdata, host_rsp_valid, host_rsp_rdata: same as the core_* equivalents, for the host
host_halt_req  in  1  host requests core halt and exclusive access
core_halted  out  1  core is drained and stalled
mem_en  out  1  BRAM port enable
mem_we  out  NB_COL  BRAM byte write enables
mem_addr  out  ADDR_WIDTH  BRAM address
mem_wdata  out  DW  BRAM write data
mem_rdata  in  DW  BRAM read data, valid RD_LAT cycles after a read enable

Behaviour:
- Handshake: a request is accepted when valid && ready. ready is combinational from valid, state and arbitration. At most one acceptance per cycle. Requester holds all req fields stable until accepted.
- mem_* are driven combinationally from the granted request. mem_en=1 only on an acceptance. mem_we=be on a write, 0 on a read. When idle, mem_en=0, mem_we=0, addr/wdata=0.
- Arbitration in RUN: if only one requester is valid, it is granted. If both are valid, grant the one not in last_grant. last_grant updates on every acceptance and resets to HOST, so the core wins the first conflict.
- Write with be=0: accepted, mem_en=1, mem_we=0, no response.
- Read response: a tag pipe of RD_LAT stages of {valid, owner} is loaded on each read acceptance. On exit, assert <owner>_rsp_valid for exactly 1 cycle, RD_LAT cycles after acceptance. <owner>_rsp_rdata=mem_rdata while valid, otherwise 0. Writes produce no response. Back-to-back reads give back-to-back responses in order.
- Halt FSM (states RUN, DRAIN, HALTED):
  RUN: arbitrate normally; host_halt_req=1 -> DRAIN.
  DRAIN: core_req_ready=0, host served normally. Transition to HALTED in the first cycle with no core-owned entry in the tag pipe. host_halt_req=0 -> RUN, which takes priority over the HALTED transition.
  HALTED: core_halted=1, core_req_ready=0, host granted whenever valid. host_halt_req=0 -> RUN, and core_halted falls in the same cycle as the state change.
- core_halted is registered: it equals (state==HALTED).
- Reset values: all ready=0, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, core_halted=0, state=RUN, tag pipe cleared, last_grant=HOST.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid is produced after reset.
- No address-range checking; the address width makes every address legal.

Decomposition:
- riscv_pkg additions:
  - arb_state_t enum {ARB_RUN, ARB_DRAIN, ARB_HALTED}
  - mem_owner_t enum {OWNER_CORE=0, OWNER_HOST=1}
  - rsp_tag_t packed struct {valid, owner}
  - MAX_RD_LAT=3
- One sub-module, briski_rsp_tag_pipe: a parameterised RD_LAT shift register of rsp_tag_t with synchronous clear. It outputs the exiting tag and a has_core flag (OR over stages of valid && owner==CORE) for DRAIN.

Test Plan:
1. Core-only read, RD_LAT=1, addr 0x010 with BRAM word 0xDEADBEEF -> mem_en=1 and mem_we=0 in cycle T; core_rsp_valid=1 with rdata 0xDEADBEEF in T+1; host_rsp_valid stays 0.
2. Both valid every cycle for 4 cycles, both reads -> grants alternate C,H,C,H. Responses go to C,H,C,H in order, each RD_LAT cycles after grant (rerun with RD_LAT=2 and 3).
3. Core write be=4'b0011, wdata 0x12345678 -> mem_we=4'b0011 for one cycle, no rsp_valid; a following read returns 0xXXXX5678 per BRAM model.
4. Core read accepted at T (RD_LAT=3), host_halt_req=1 at T+1 -> DRAIN from T+2, core_req_ready=0; core response at T+3; HALTED then core_halted=1 at T+4 and T+5; host writes accepted every cycle while halted.
5. host_halt_req dropped while in DRAIN -> return to RUN, core_halted never asserts, core served on next valid.
6. reset_n=0 for 1 cycle with 2 reads in flight (RD_LAT=2) -> no rsp_valid afterward, all outputs at reset values, state=RUN, next conflict granted to core.
